bmp280_seq: RTL

//  Transaction sequencer for the BMP280 SPI message engine (spi_msg).

---
 rtl/bmp280_seq_pkg.sv | 41 ++++
 rtl/bmp280_seq_poll_timer.sv | 34 +++
 rtl/bmp280_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bmp280_seq_pkg.sv
// bmp280_seq_pkg: shared definitions for the BMP280 sequencer.
//  Register addresses, chip ID, SPI frame bit positions, FSM state encoding
//  and a helper that packs a 16-bit spi_msg frame.
//  The chip-ID constants exist only when BMP280_ID_CHECK_EN is defined.
package bmp280_seq_pkg;

   localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
   localparam logic [7:0] REG_CONFIG    = 8'hF5;
   localparam logic [7:0] REG_PRESS_MSB = 8'hF7;
`ifdef BMP280_ID_CHECK_EN
   localparam logic [7:0] REG_ID        = 8'hD0;
   localparam logic [7:0] CHIP_ID       = 8'h58;
`endif

   localparam int FRM_RW_BIT   = 15;
   localparam int FRM_ADDR_MSB = 14;
   localparam int FRM_ADDR_LSB = 8;
   localparam int FRM_DATA_MSB = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID,
      ST_CFG,
      ST_MEAS,
      ST_WAIT,
      ST_RD,
      ST_PUB
   } state_t;

   // Register address bit 7 is not carried in the frame; the R/W bit takes its place.
   function automatic logic [15:0] frame(input logic rd, input logic [6:0] addr,
                                         input logic [7:0] data);
      logic [15:0] f;
      f = '0;
      f[FRM_RW_BIT] = rd;
      f[FRM_ADDR_MSB:FRM_ADDR_LSB] = addr;
      f[FRM_DATA_MSB:0] = data;
      return f;
   endfunction

endpackage

// File: rtl/bmp280_seq_poll_timer.sv
// bmp280_seq_poll_timer: poll interval counter.
//  Counts 0..POLL_DIV-1 while i_clr is low and holds at POLL_DIV-1 (never wraps).
//  Ports:
//   clk12MHz  in  system clock
//   rst       in  synchronous active-high reset
//   i_clr     in  hold the counter at 0
//   o_expire  out counter has reached POLL_DIV-1
module bmp280_seq_poll_timer #(
   parameter int POLL_DIV = 1200000
) (
   input  logic clk12MHz,
   input  logic rst,
   input  logic i_clr,
   output logic o_expire
);

   localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt != LAST) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/bmp280_seq.sv
// bmp280_seq: BMP280 bring-up and polling sequencer in front of spi_msg.
//  Writes config and ctrl_meas once, then every POLL_DIV cycles reads F7..FC
//  and publishes 20-bit raw pressure/temperature words together.
//  Optional feature macro: BMP280_ID_CHECK_EN (reads and checks chip ID 0xD0 first).
//  Ports:
//   clk12MHz            in   system clock
//   rst                 in   synchronous active-high reset
//   start               in   pulse: begin init and polling (ignored while busy)
//   spi_go / spi_tx     out  frame request pulse and 16-bit frame
//   spi_done / spi_rx   in   frame complete pulse and received frame
//   press_raw/temp_raw  out  20-bit raw words, updated only with sample_valid
//   sample_valid        out  pulse: raw words updated this cycle
//   busy                out  sequencer active
//   id_err              out  sticky chip-ID mismatch (0 without BMP280_ID_CHECK_EN)
//
//  state   | meaning
//  IDLE    | waiting for start
//  ID      | reading chip ID (BMP280_ID_CHECK_EN only)
//  CFG     | writing config register
//  MEAS    | writing ctrl_meas register
//  WAIT    | poll interval running
//  RD      | reading data byte r_rd_idx (0..5 = F7..FC)
//  PUB     | publishing shadow bytes to the outputs
module bmp280_seq
   import bmp280_seq_pkg::*;
#(
   parameter int         POLL_DIV  = 1200000,
   parameter logic [7:0] CTRL_MEAS = 8'h27,
   parameter logic [7:0] CONFIG    = 8'h00
) (
   input  logic        clk12MHz,
   input  logic        rst,
   input  logic        start,
   output logic        spi_go,
   output logic [15:0] spi_tx,
   input  logic        spi_done,
   input  logic [15:0] spi_rx,
   output logic [19:0] press_raw,
   output logic [19:0] temp_raw,
   output logic        sample_valid,
   output logic        busy,
   output logic        id_err
);

   state_t     r_state;
   logic [2:0] r_rd_idx;
   logic [7:0] r_shadow [6];
   logic       w_expire;
   logic       w_tmr_clr;
   logic [7:0] w_rd_next_addr;
   logic       w_unused_bits;

   // Keeping the timer cleared outside WAIT gives a fresh count on every entry.
   assign w_tmr_clr      = (r_state != ST_WAIT);
   assign w_rd_next_addr = REG_PRESS_MSB + 8'(r_rd_idx) + 8'd1;
   assign w_unused_bits  = ^{spi_rx[15:8], r_shadow[2][3:0], r_shadow[5][3:0]};

   bmp280_seq_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
      .clk12MHz (clk12MHz),
      .rst      (rst),
      .i_clr    (w_tmr_clr),
      .o_expire (w_expire)
   );

`ifdef BMP280_ID_CHECK_EN
   logic r_id_err;
   assign id_err = r_id_err;
`else
   assign id_err = 1'b0;
`endif

   always_ff @(posedge clk12MHz) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rd_idx     <= '0;
         spi_go       <= 1'b0;
         spi_tx       <= '0;
         press_raw    <= '0;
         temp_raw     <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
`ifdef BMP280_ID_CHECK_EN
         r_id_err     <= 1'b0;
`endif
      end else begin
         spi_go       <= 1'b0;
         sample_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  spi_go <= 1'b1;
`ifdef BMP280_ID_CHECK_EN
                  r_id_err <= 1'b0;
                  r_state  <= ST_ID;
                  spi_tx   <= frame(1'b1, REG_ID[6:0], 8'h00);
`else
                  r_state  <= ST_CFG;
                  spi_tx   <= frame(1'b0, REG_CONFIG[6:0], CONFIG);
`endif
               end
            end
`ifdef BMP280_ID_CHECK_EN
            ST_ID: begin
               if (spi_done) begin
                  if (spi_rx[7:0] == CHIP_ID) begin
                     r_state <= ST_CFG;
                     spi_go  <= 1'b1;
                     spi_tx  <= frame(1'b0, REG_CONFIG[6:0], CONFIG);
                  end else begin
                     r_id_err <= 1'b1;
                     busy     <= 1'b0;
                     r_state  <= ST_IDLE;
                  end
               end
            end
`endif
            ST_CFG: begin
               if (spi_done) begin
                  r_state <= ST_MEAS;
                  spi_go  <= 1'b1;
                  spi_tx  <= frame(1'b0, REG_CTRL_MEAS[6:0], CTRL_MEAS);
               end
            end
            ST_MEAS: begin
               if (spi_done) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_expire) begin
                  r_state  <= ST_RD;
                  r_rd_idx <= '0;
                  spi_go   <= 1'b1;
                  spi_tx   <= frame(1'b1, REG_PRESS_MSB[6:0], 8'h00);
               end
            end
            ST_RD: begin
               if (spi_done) begin
                  r_shadow[r_rd_idx] <= spi_rx[7:0];
                  if (r_rd_idx == 3'd5) begin
                     r_state <= ST_PUB;
                  end else begin
                     r_rd_idx <= r_rd_idx + 3'd1;
                     spi_go   <= 1'b1;
                     spi_tx   <= frame(1'b1, w_rd_next_addr[6:0], 8'h00);
                  end
               end
            end
            ST_PUB: begin
               press_raw    <= {r_shadow[0], r_shadow[1], r_shadow[2][7:4]};
               temp_raw     <= {r_shadow[3], r_shadow[4], r_shadow[5][7:4]};
               sample_valid <= 1'b1;
               r_state      <= ST_WAIT;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
